imm_prefix_ext: RTL
===================

Name: imm_prefix_ext

Overview:
- Parametrised immediate generator for the decode stage. It is the next generation of the 16-bit combinational sign-extender.
- Adds an IMM-prefix mechanism: one or more prefix instructions accumulate upper immediate bits, and the next immediate-using instruction consumes them. This builds XLEN-wide constants.
- Adds a zero-extended format, a registered output with valid, and flush/stall handling.
- Sits between instruction register and register-read/ALU operand mux.

Parameters:
- XLEN, 16, output immediate width; must be >= 16.
- PFX_W, 11, payload bits per prefix (In[PFX_W-1:0]); fixed by the ISA encoding.
- PFX_MAX, 2, maximum accumulated prefixes; the accumulator is PFX_MAX*PFX_W bits.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- In  in  16  instruction word
- ImmSrc  in  3  format: 000 none, 001 I, 010 SB, 011 JL, 100 UI (unsigned I), 101 PREFIX, 110/111 reserved (treated as none)
- in_valid  in  1  In/ImmSrc valid this cycle
- stall  in  1  hold all state and outputs
- flush  in  1  discard the current instruction and the pending prefix
- Imm_Ext  out  XLEN  registered immediate
- imm_valid  out  1  Imm_Ext valid (one cycle per accepted non-prefix instruction)
- pfx_pending  out  1  at least one prefix is held
- pfx_err  out  1  one-cycle pulse: prefix overflow or orphaned prefix

Behaviour:
- Reset (async, rst_n=0):
  - Imm_Ext=0, imm_valid=0, pfx_pending=0, pfx_err=0.
  - Accumulator acc=0, count k=0.
- Accept condition: accept = in_valid & ~stall & ~flush. Latency is 1 cycle: outputs update on the edge after accept.
- Priority: flush > stall > accept.
  - flush=1: k=0, acc=0, imm_valid=0, pfx_err=0; Imm_Ext holds. This applies even when stall=1.
  - stall=1 (no flush): every register holds, including imm_valid and pfx_err.
  - No accept and no stall/flush: imm_valid=0, pfx_err=0, Imm_Ext holds.
- Raw field F and width W per format:
  - I: F=In[15:11], W=5, signed.
  - SB: F={In[15:14],In[5:3]}, W=5, signed.
  - JL: F={In[15],In[10:6],In[14:11]}, W=10, signed.
  - UI: F=In[15:11], W=5, zero-extended.
- Accepted PREFIX:
  - acc = {acc, In[PFX_W-1:0]} (shift left by PFX_W, drop the top bits). k = min(k+1, PFX_MAX).
  - If k was already PFX_MAX, pulse pfx_err. The oldest payload is lost.
  - imm_valid=0.
- Accepted I/SB/JL/UI:
  - V = {acc[k*PFX_W-1:0], F}, of width k*PFX_W+W.
  - Imm_Ext = V sign-extended from its MSB (signed formats) or zero-extended (UI), truncated to the low XLEN bits.
  - imm_valid=1, then k=0 and acc=0.
  - With k=0 the result is identical to the legacy extender (JL sign bit = In[15]).
- Accepted none/reserved:
  - Imm_Ext=0, imm_valid=1.
  - If k>0, pulse pfx_err (orphaned prefix) and clear k and acc.
- pfx_pending = (k != 0), registered.
- Prefix with k=PFX_MAX and flush in the same cycle: flush wins, no pfx_err.

Decomposition:
- Shared package:
  - ImmSrc encodings: IMM_NONE, IMM_I, IMM_SB, IMM_JL, IMM_UI, IMM_PFX.
  - Field-width constants: W_I, W_SB, W_JL, PFX_W.
- One natural sub-module, imm_field_sel (combinational): In and ImmSrc -> F, W, signed flag.
- Accumulator, counter and output registers live in the top.

Test Plan:
- XLEN=16, reset release; I with In[15:11]=10101 -> next cycle Imm_Ext=16'hFFF5, imm_valid=1; UI with the same word -> 16'h0015.
- XLEN=16: PREFIX In[10:0]=11'h001, then I with In[15:11]=00011 -> Imm_Ext=16'h0023, pfx_pending 1 then 0.
- XLEN=32, PFX_MAX=2: PREFIX 11'h400, PREFIX 11'h000, then I F=0 -> 32'hFC000000; a third prefix before the consumer -> pfx_err pulse, k stays 2.
- Pending prefix, then ImmSrc=000 -> Imm_Ext=0, imm_valid=1, pfx_err=1 for one cycle, pfx_pending=0.
- Stall for 3 cycles with in_valid=1 -> no output change; then flush with a prefix pending -> pfx_pending=0 and imm_valid=0 next cycle.
- Assert rst_n=0 mid-stream (prefix pending, imm_valid=1) between clock edges -> all outputs 0 immediately; the first I after release carries no prefix.

Source files
------------

// File: rtl/imm_prefix_ext_pkg.sv
// Shared definitions for the prefixed immediate generator.
//   imm_src_e : ImmSrc encodings (110/111 reserved, decoded as "none")
//   W_*       : raw immediate field widths per format
//   PFX_W     : payload bits carried by one IMM-prefix instruction
package imm_prefix_ext_pkg;

  typedef enum logic [2:0] {
    IMM_NONE = 3'b000,
    IMM_I    = 3'b001,
    IMM_SB   = 3'b010,
    IMM_JL   = 3'b011,
    IMM_UI   = 3'b100,
    IMM_PFX  = 3'b101
  } imm_src_e;

  localparam int W_I   = 5;
  localparam int W_SB  = 5;
  localparam int W_JL  = 10;
  localparam int W_UI  = 5;
  localparam int W_MAX = 10;   // widest raw field (JL)
  localparam int PFX_W = 11;   // prefix payload, In[10:0]

endpackage

// File: rtl/imm_field_sel.sv
// Raw immediate field extraction (combinational).
// Ports:
//   i_instr   [15:0]      instruction word
//   i_imm_src [2:0]       immediate format
//   o_field   [W_MAX-1:0] raw field F, right-aligned, upper bits zero
//   o_width   [3:0]       number of valid bits W in o_field
//   o_signed              1 = sign-extend from the combined MSB
module imm_field_sel
  import imm_prefix_ext_pkg::*;
(
  input  logic [15:0]      i_instr,
  input  logic [2:0]       i_imm_src,
  output logic [W_MAX-1:0] o_field,
  output logic [3:0]       o_width,
  output logic             o_signed
);

  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    o_field  = '0;
    o_width  = 4'(W_I);
    o_signed = 1'b0;
    case (imm_src_e'(i_imm_src))
      IMM_I: begin
        o_field  = W_MAX'(i_instr[15:11]);
        o_width  = 4'(W_I);
        o_signed = 1'b1;
      end
      IMM_SB: begin
        o_field  = W_MAX'({i_instr[15:14], i_instr[5:3]});
        o_width  = 4'(W_SB);
        o_signed = 1'b1;
      end
      IMM_JL: begin
        // In[15] lands in the MSB, so with no prefix it is the sign bit.
        o_field  = {i_instr[15], i_instr[10:6], i_instr[14:11]};
        o_width  = 4'(W_JL);
        o_signed = 1'b1;
      end
      IMM_UI: begin
        o_field  = W_MAX'(i_instr[15:11]);
        o_width  = 4'(W_UI);
        o_signed = 1'b0;
      end
      default: ;  // none, prefix and reserved carry no field
    endcase
  end

endmodule

// File: rtl/imm_prefix_ext.sv
// Immediate generator with IMM-prefix accumulation, registered output.
// Prefix instructions shift their payload into an accumulator; the next
// immediate-using instruction prepends the accumulated bits to its own field.
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   In [15:0]    instruction word
//   ImmSrc [2:0] format (none/I/SB/JL/UI/PREFIX, reserved = none)
//   in_valid     In/ImmSrc valid this cycle
//   stall        hold all state and outputs
//   flush        drop the current instruction and any pending prefix
//   Imm_Ext      registered immediate, XLEN bits
//   imm_valid    one-cycle pulse per accepted non-prefix instruction
//   pfx_pending  at least one prefix is held
//   pfx_err      one-cycle pulse on prefix overflow or orphaned prefix
module imm_prefix_ext #(
  parameter int XLEN    = 16,
  parameter int PFX_W   = imm_prefix_ext_pkg::PFX_W,
  parameter int PFX_MAX = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [15:0]     In,
  input  logic [2:0]      ImmSrc,
  input  logic            in_valid,
  input  logic            stall,
  input  logic            flush,
  output logic [XLEN-1:0] Imm_Ext,
  output logic            imm_valid,
  output logic            pfx_pending,
  output logic            pfx_err
);

  import imm_prefix_ext_pkg::imm_src_e;
  import imm_prefix_ext_pkg::IMM_I;
  import imm_prefix_ext_pkg::IMM_SB;
  import imm_prefix_ext_pkg::IMM_JL;
  import imm_prefix_ext_pkg::IMM_UI;
  import imm_prefix_ext_pkg::IMM_PFX;
  import imm_prefix_ext_pkg::W_MAX;

  localparam int ACC_W = PFX_MAX * PFX_W;
  localparam int V_W   = ACC_W + W_MAX;
  // Work wide enough for the largest combined value and for XLEN itself.
  localparam int EXT_W = (XLEN > V_W) ? XLEN : V_W;
  localparam int CNT_W = $clog2(PFX_MAX + 1);

  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_k;
  logic [XLEN-1:0]  r_imm;
  logic             r_valid;
  logic             r_err;

  logic [W_MAX-1:0] w_field;
  logic [3:0]       w_width;
  logic             w_signed;
  logic [31:0]      w_acc_bits;
  logic [31:0]      w_nbits;
  logic [ACC_W-1:0] w_acc_live;
  logic [EXT_W-1:0] w_v;
  logic [EXT_W-1:0] w_v_msb;
  logic             w_sign;
  logic [EXT_W-1:0] w_ext;
  logic             w_pfx_full;

  imm_field_sel u_field_sel (
    .i_instr   (In),
    .i_imm_src (ImmSrc),
    .o_field   (w_field),
    .o_width   (w_width),
    .o_signed  (w_signed)
  );

  // Combined value V = {acc[k*PFX_W-1:0], F}; n = k*PFX_W + W bits long.
  assign w_acc_bits = 32'(r_k) * 32'(PFX_W);
  assign w_nbits    = w_acc_bits + 32'(w_width);
  // Shifting by the full ACC_W yields 0, so the mask becomes all ones at k=PFX_MAX.
  assign w_acc_live = r_acc & ((ACC_W'(1) << w_acc_bits) - ACC_W'(1));
  assign w_v        = (EXT_W'(w_acc_live) << w_width) | EXT_W'(w_field);
  assign w_v_msb    = w_v >> (w_nbits - 32'd1);
  assign w_sign     = w_signed & w_v_msb[0];
  assign w_ext      = w_sign ? (w_v | ~((EXT_W'(1) << w_nbits) - EXT_W'(1))) : w_v;
  assign w_pfx_full = (r_k == CNT_W'(PFX_MAX));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_k     <= '0;
      r_imm   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else if (flush) begin
      // Flush beats stall; Imm_Ext keeps its last value.
      r_acc   <= '0;
      r_k     <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else if (!stall) begin
      if (!in_valid) begin
        r_valid <= 1'b0;
        r_err   <= 1'b0;
      end else begin
        case (imm_src_e'(ImmSrc))
          IMM_PFX: begin
            // Oldest payload falls off the top when the accumulator is full.
            r_acc   <= (r_acc << PFX_W) | ACC_W'(In[PFX_W-1:0]);
            r_k     <= w_pfx_full ? r_k : r_k + CNT_W'(1);
            r_err   <= w_pfx_full;
            r_valid <= 1'b0;
          end
          IMM_I, IMM_SB, IMM_JL, IMM_UI: begin
            r_imm   <= w_ext[XLEN-1:0];
            r_valid <= 1'b1;
            r_err   <= 1'b0;
            r_acc   <= '0;
            r_k     <= '0;
          end
          default: begin
            // No immediate consumer: any held prefix is orphaned.
            r_imm   <= '0;
            r_valid <= 1'b1;
            r_err   <= (r_k != '0);
            r_acc   <= '0;
            r_k     <= '0;
          end
        endcase
      end
    end
  end

  assign Imm_Ext     = r_imm;
  assign imm_valid   = r_valid;
  assign pfx_pending = (r_k != '0);
  assign pfx_err     = r_err;

endmodule
